// File: rtl/bsg_credit_rr_arb_pkg.sv
// Package: bsg_credit_rr_arb_pkg
// Shared types and helpers for bsg_credit_rr_arb.
//   lg_c_f        width of a credit counter able to hold 0..max_credits
//   credit_cnt_t  credit counter type sized for the default max_credits_p of 8
//   cnt_op_e      credit counter operation selected each cycle
// Build option: BSG_CREDIT_RR_ARB_BYPASS_EN (used by the top level, not here).
package bsg_credit_rr_arb_pkg;

    function automatic int unsigned lg_c_f(input int unsigned max_credits);
        return $clog2(max_credits + 1);
    endfunction

    localparam int unsigned MaxCreditsDefault = 8;
    localparam int unsigned LgCDefault        = lg_c_f(MaxCreditsDefault);

    typedef logic [LgCDefault-1:0] credit_cnt_t;

    typedef enum logic [1:0] {
        CntNop,
        CntInc,
        CntDec
    } cnt_op_e;

endpackage

// File: rtl/bsg_credit_rr_arb_pick.sv
// Module: bsg_credit_rr_arb_pick
// Combinational rotate-priority finder: scans v_i starting at rr_ptr_i, wrapping modulo
// els_p, and reports the first set bit.
// Ports:
//   v_i       in   els_p   request vector
//   rr_ptr_i  in   PtrW    index with highest priority this cycle
//   grant_o   out  els_p   one-hot winner (zero when no request)
//   idx_o     out  PtrW    encoded winner (zero when no request)
//   any_o     out  1       at least one request present
module bsg_credit_rr_arb_pick
    import bsg_credit_rr_arb_pkg::*;
#(
    parameter  int unsigned els_p = 4,
    localparam int unsigned PtrW  = $clog2(els_p)
) (
    input  logic [els_p-1:0] v_i,
    input  logic [PtrW-1:0]  rr_ptr_i,
    output logic [els_p-1:0] grant_o,
    output logic [PtrW-1:0]  idx_o,
    output logic             any_o
);

    int unsigned    k;
    logic [PtrW-1:0] ki;
    logic           found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |v_i;
        found   = 1'b0;
        k       = 0;
        ki      = '0;
        for (int unsigned off = 0; off < els_p; off++) begin
            k  = (32'(rr_ptr_i) + off) % els_p;
            ki = PtrW'(k);
            if (!found && v_i[ki]) begin
                found       = 1'b1;
                grant_o[ki] = 1'b1;
                idx_o       = ki;
            end
        end
    end

endmodule

// File: rtl/bsg_credit_rr_arb.sv
// Module: bsg_credit_rr_arb
// Shares one credit-flow-controlled output channel among els_p valid/yumi requesters.
// Holds the sender-side credit count, grants round-robin while credit is available and
// muxes the granted payload onto the channel.
// Ports:
//   clk_i         in   1              clock
//   reset_i       in   1              synchronous active-high reset
//   v_i           in   els_p          requester valid
//   data_i        in   els_p*width_p  payload, requester k at [k*width_p +: width_p]
//   yumi_o        out  els_p          one-hot grant
//   v_o           out  1              channel valid, consumes one credit
//   data_o        out  width_p        granted payload
//   tag_o         out  $clog2(els_p)  granted requester index
//   credit_i      in   1              one credit returned
//   credit_cnt_o  out  lg_c           registered credit count
//   overflow_o    out  1              sticky: credit returned beyond max_credits_p
// Build option: BSG_CREDIT_RR_ARB_BYPASS_EN lets a credit returned at count 0 be spent
// in the same cycle.
module bsg_credit_rr_arb
    import bsg_credit_rr_arb_pkg::*;
#(
    parameter  int unsigned els_p         = 4,
    parameter  int unsigned width_p       = 8,
    parameter  int unsigned max_credits_p = 8,
    localparam int unsigned PtrW          = $clog2(els_p),
    localparam int unsigned LgC           = lg_c_f(max_credits_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*width_p-1:0] data_i,
    output logic [els_p-1:0]         yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic [PtrW-1:0]          tag_o,
    input  logic                     credit_i,
    output logic [LgC-1:0]           credit_cnt_o,
    output logic                     overflow_o
);

    localparam logic [LgC-1:0] MaxCnt = LgC'(max_credits_p);

    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LgC-1:0]   credit_cnt_q, credit_cnt_d;
    logic             overflow_q, overflow_d;

    logic [els_p-1:0] pick_grant;
    logic [PtrW-1:0]  pick_idx;
    logic             pick_any;
    logic             avail;
    logic             grant;
    cnt_op_e          cnt_op;

    bsg_credit_rr_arb_pick #(
        .els_p (els_p)
    ) u_pick (
        .v_i      (v_i),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_grant),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

`ifdef BSG_CREDIT_RR_ARB_BYPASS_EN
    // A credit arriving at zero is forwarded straight into this cycle's send.
    assign avail = (credit_cnt_q != '0) | credit_i;
`else
    assign avail = (credit_cnt_q != '0);
`endif

    assign grant = avail & pick_any & ~reset_i;

    always_comb begin
        v_o    = grant;
        yumi_o = grant ? pick_grant : '0;
        tag_o  = grant ? pick_idx : '0;
        data_o = grant ? data_i[32'(pick_idx)*width_p +: width_p] : '0;
    end

    always_comb begin
        cnt_op = CntNop;
        if (grant && !credit_i) begin
            cnt_op = CntDec;
        end else if (!grant && credit_i) begin
            cnt_op = CntInc;
        end
    end

    always_comb begin
        credit_cnt_d = credit_cnt_q;
        overflow_d   = overflow_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (32'(pick_idx) == els_p - 1) ? '0 : pick_idx + PtrW'(1);
        end
        unique case (cnt_op)
            CntDec: credit_cnt_d = credit_cnt_q - LgC'(1);
            CntInc: begin
                // Excess credit saturates at max and latches the error flag.
                if (credit_cnt_q == MaxCnt) begin
                    overflow_d = 1'b1;
                end else begin
                    credit_cnt_d = credit_cnt_q + LgC'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credit_cnt_q <= MaxCnt;
            rr_ptr_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            credit_cnt_q <= credit_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            overflow_q   <= overflow_d;
        end
    end

    assign credit_cnt_o = credit_cnt_q;
    assign overflow_o   = overflow_q;

endmodule
